// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_pkg
// Purpose : Shared definitions for the VGA pattern generator: pattern-select
//           encodings and a constant-function ceil(log2) helper.
// Ports   : none (package)
// Revision: 1.0 - initial parametrised release
// ============================================================================
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_GRAD  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_EXT   = 2'd3
  } mode_e;

  // Bits needed to hold 0..v-1; never returns less than 1 so a width of 0
  // can never be produced for degenerate sizes.
  function automatic int vga_clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_pattern_gen_if
// Purpose : Bundles the video-side signals of vga_pattern_gen.
//           master : the generator (drives coordinates, pixel, sync, strobes)
//           slave  : the consumer / pixel source (drives en, mode, ext_pixel)
// Signals : en, mode[1:0], ext_pixel[PIX_W], ext_x[XW], ext_y[YW],
//           pixel[PIX_W], de, hsync, vsync, frame_start, line_start
// Revision: 1.0 - initial parametrised release
// ============================================================================
interface vga_pattern_gen_if #(
  parameter int PIX_W = 8,
  parameter int XW    = 10,
  parameter int YW    = 9
);
  logic             en;
  logic [1:0]       mode;
  logic [PIX_W-1:0] ext_pixel;
  logic [XW-1:0]    ext_x;
  logic [YW-1:0]    ext_y;
  logic [PIX_W-1:0] pixel;
  logic             de;
  logic             hsync;
  logic             vsync;
  logic             frame_start;
  logic             line_start;

  modport master (
    input  en, mode, ext_pixel,
    output ext_x, ext_y, pixel, de, hsync, vsync, frame_start, line_start
  );

  modport slave (
    output en, mode, ext_pixel,
    input  ext_x, ext_y, pixel, de, hsync, vsync, frame_start, line_start
  );
endinterface
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
// Module  : vga_axis_counter
// Purpose : One timing axis (horizontal or vertical). Counts 0..TOTAL-1 while
//           inc is high and decodes active / sync / last from the count.
// Ports   : clk, rst (sync, active-high), inc -> count[W], last, active, sync
// Revision: 1.0 - initial parametrised release
// ============================================================================
module vga_axis_counter #(
  parameter int ACTIVE = 720,
  parameter int FP     = 36,
  parameter int SYNC   = 72,
  parameter int BP     = 108,
  parameter int W      = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         last,
  output logic         active,
  output logic         sync
);
  localparam int TOTAL      = ACTIVE + FP + SYNC + BP;
  localparam int SYNC_START = ACTIVE + FP;
  localparam int SYNC_END   = ACTIVE + FP + SYNC;

  logic [W-1:0] cnt;

  assign count  = cnt;
  assign last   = (cnt == W'(TOTAL - 1));
  assign active = (cnt < W'(ACTIVE));
  assign sync   = (cnt >= W'(SYNC_START)) && (cnt < W'(SYNC_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : vga_pattern_gen
// Purpose : Parametrised VGA timing and test-pattern generator. Stage 0 is the
//           pair of axis counters (exported as ext_x/ext_y so an external
//           bitmap source can answer combinationally); stage 1 registers
//           pixel, de, syncs and frame/line strobes. Pattern select is taken
//           at the last pixel of a frame so a new pattern starts cleanly.
// Ports   : clk, rst (sync, active-high), bus (vga_pattern_gen_if.master)
// Options : VGA_PAT_SCROLL_EN - adds a 6-bit frame counter that scrolls the
//           gradient pattern one column every 4 frames (wraps at 16).
// Revision: 1.0 - initial parametrised release
// ============================================================================
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 720,
  parameter int H_FP     = 36,
  parameter int H_SYNC   = 72,
  parameter int H_BP     = 108,
  parameter int V_ACTIVE = 400,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 41,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIX_W    = 8,
  parameter int CHK_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst,
  vga_pattern_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = vga_clog2(H_TOTAL);
  localparam int YW      = vga_clog2(V_TOTAL);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      (PIX_W % 2) != 0 || PIX_W < 4) begin : g_bad_params
    $fatal(1, "vga_pattern_gen: axis sizes must be > 0 and PIX_W even and >= 4");
  end

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          h_last, h_act, h_sync;
  logic          v_last, v_act, v_sync;
  logic          frame_end;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(XW)
  ) u_h_axis (
    .clk(clk), .rst(rst), .inc(bus.en),
    .count(x), .last(h_last), .active(h_act), .sync(h_sync)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(YW)
  ) u_v_axis (
    .clk(clk), .rst(rst), .inc(bus.en & h_last),
    .count(y), .last(v_last), .active(v_act), .sync(v_sync)
  );

  assign bus.ext_x = x;
  assign bus.ext_y = y;
  assign frame_end = bus.en & h_last & v_last;

  // Mode only changes at the frame boundary so no frame shows a torn pattern.
  mode_e mode_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_GRAD;
    end else if (frame_end) begin
      mode_q <= mode_e'(bus.mode);
    end
  end

  logic [3:0] scroll;
`ifdef VGA_PAT_SCROLL_EN
  logic [5:0] fcnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= '0;
    end else if (frame_end) begin
      fcnt <= fcnt + 6'd1;
    end
  end
  assign scroll = fcnt[5:2];
`else
  assign scroll = 4'd0;
`endif

  logic [XW-1:0]    grad_x;
  logic [2:0]       bar;
  logic [PIX_W-1:0] pat;

  always_comb begin
    grad_x = x + XW'(scroll);
    // Bar index only meaningful inside the active area; blanking masks it.
    bar    = 3'((int'(x) * 8) / H_ACTIVE);
    pat    = '0;
    unique case (mode_q)
      MODE_GRAD:  pat = {y[PIX_W/2-1:0], grad_x[PIX_W/2-1:0]};
      MODE_BARS: begin
        // Bar index repeated MSB-first, truncated to the pixel width.
        for (int i = 0; i < PIX_W; i++) pat[PIX_W-1-i] = bar[2 - (i % 3)];
      end
      MODE_CHECK: pat = {PIX_W{x[CHK_LOG2] ^ y[CHK_LOG2]}};
      MODE_EXT:   pat = bus.ext_pixel;
      default:    pat = '0;
    endcase
  end

  logic [PIX_W-1:0] pixel_q;
  logic             de_q, hsync_q, vsync_q, fs_q, ls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_q <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else if (bus.en) begin
      pixel_q <= (h_act && v_act) ? pat : '0;
      de_q    <= h_act && v_act;
      hsync_q <= h_sync ? HS_POL : ~HS_POL;
      vsync_q <= v_sync ? VS_POL : ~VS_POL;
      fs_q    <= (x == '0) && (y == '0);
      ls_q    <= (x == '0);
    end
  end

  assign bus.pixel       = pixel_q;
  assign bus.de          = de_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.frame_start = fs_q;
  assign bus.line_start  = ls_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_pattern_gen
// Purpose : Self-checking bench for vga_pattern_gen using a reduced timing
//           (28 x 17 total) so whole frames are cheap. Expected outputs come
//           from a position/frame arithmetic model driven by the count of
//           enabled cycles since reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;
  import vga_pkg::*;

  localparam int HA = 20, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 12, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int XW = vga_clog2(HT);
  localparam int YW = vga_clog2(VT);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_pattern_gen_if #(.PIX_W(8), .XW(XW), .YW(YW)) bus ();

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_W(8), .CHK_LOG2(3)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int salt = 0;

  function automatic logic [7:0] rom_f(input int x, input int y, input int s);
    return 8'(((x * 29) + (y * 11)) ^ s);
  endfunction

  // Pixel source: answers combinationally for the coordinate presented.
  always_comb bus.ext_pixel = rom_f(int'(bus.ext_x), int'(bus.ext_y), salt);

  function automatic logic [7:0] pix_ref(input int x, input int y, input int m,
                                         input int sc, input int s);
    int b;
    if (x >= HA || y >= VA) return 8'h00;
    case (m)
      0: return 8'(((y % 16) * 16) + ((x + sc) % 16));
      1: begin
        b = (x * 8) / HA;
        return 8'((b * 73) >> 1);   // {b,b,b} is 9 bits; keep the top 8
      end
      2: return (((x / 8) % 2) != ((y / 8) % 2)) ? 8'hFF : 8'h00;
      default: return rom_f(x, y, s);
    endcase
  endfunction

  // Model state
  int k, mode_eff, frames, last_px, last_py;
  logic [7:0] e_pix;
  logic e_de, e_hs, e_vs, e_fs, e_ls;
  int errors = 0, checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic r);
    int px, py, sc;
    bus.en = e;
    rst    = r;
    @(posedge clk);
    if (r) begin
      k = 0; mode_eff = 0; frames = 0; last_px = -1; last_py = -1;
      e_pix = 8'h00; e_de = 0; e_hs = 1; e_vs = 1; e_fs = 0; e_ls = 0;
    end else if (e) begin
      px = k % HT;
      py = (k / HT) % VT;
`ifdef VGA_PAT_SCROLL_EN
      sc = (frames % 64) / 4;
`else
      sc = 0;
`endif
      e_pix = pix_ref(px, py, mode_eff, sc, salt);
      e_de  = (px < HA) && (py < VA);
      e_hs  = !((px >= HA + HFP) && (px < HA + HFP + HS));
      e_vs  = !((py >= VA + VFP) && (py < VA + VFP + VS));
      e_fs  = (px == 0) && (py == 0);
      e_ls  = (px == 0);
      last_px = px;
      last_py = py;
      if (px == HT - 1 && py == VT - 1) begin
        mode_eff = int'(bus.mode);
        frames++;
      end
      k++;
    end
    #1;
    chk("pixel", 32'(bus.pixel), 32'(e_pix));
    chk("de", 32'(bus.de), 32'(e_de));
    chk("hsync", 32'(bus.hsync), 32'(e_hs));
    chk("vsync", 32'(bus.vsync), 32'(e_vs));
    chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
    chk("line_start", 32'(bus.line_start), 32'(e_ls));
    chk("ext_x", 32'(bus.ext_x), 32'(k % HT));
    chk("ext_y", 32'(bus.ext_y), 32'((k / HT) % VT));
  endtask

  task automatic run_until(input int tx, input int ty);
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      step(1'b1, 1'b0);
      if (last_px == tx && last_py == ty) break;
    end
    chk("reach_pos", 32'(last_px * 1000 + last_py), 32'(tx * 1000 + ty));
  endtask

  initial begin
    int n_hs, n_vs, n_de, prev_hs, clk_cnt, fall1, fall2;
    bus.mode = 2'd0;
    bus.en   = 1'b0;

    // Reset state and hold with en low
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    chk("first_frame_start", 32'(bus.frame_start), 32'd1);

    // Gradient, one frame settle then one frame of counts
    for (int i = 0; i < FRAME - 1; i++) step(1'b1, 1'b0);
    n_hs = 0; n_vs = 0; n_de = 0;
    for (int i = 0; i < FRAME; i++) begin
      step(1'b1, 1'b0);
      n_hs += (bus.hsync == 1'b0) ? 1 : 0;
      n_vs += (bus.vsync == 1'b0) ? 1 : 0;
      n_de += (bus.de == 1'b1) ? 1 : 0;
    end
    chk("hsync_low_count", 32'(n_hs), 32'(HS * VT));
    chk("vsync_low_count", 32'(n_vs), 32'(VS * HT));
    chk("de_high_count", 32'(n_de), 32'(HA * VA));

    // Reset mid-line
    run_until(10, 5);
    step(1'b1, 1'b1);
    chk("rst_pixel", 32'(bus.pixel), 32'd0);
    chk("rst_de", 32'(bus.de), 32'd0);
    chk("rst_hsync", 32'(bus.hsync), 32'd1);
    chk("rst_vsync", 32'(bus.vsync), 32'd1);
    step(1'b1, 1'b0);
    chk("rst_frame_start", 32'(bus.frame_start), 32'd1);

    // Mode change mid-frame takes effect at next frame
    run_until(0, 5);
    bus.mode = 2'd2;
    run_until(HT - 1, VT - 1);
    step(1'b1, 1'b0);
    chk("check_px0", 32'(bus.pixel), 32'h00);
    run_until(8, 0);
    chk("check_px8", 32'(bus.pixel), 32'hFF);

    // External pixel source
    bus.mode = 2'd3;
    salt = int'($urandom_range(0, 255));
    run_until(HT - 1, VT - 1);
    run_until(5, 3);
    chk("ext_px", 32'(bus.pixel), 32'(rom_f(5, 3, salt)));
    run_until(HA, 3);
    chk("ext_blank", 32'(bus.pixel), 32'd0);

    // en toggling halves the line rate
    prev_hs = 1; clk_cnt = 0; fall1 = -1; fall2 = -1;
    for (int i = 0; i < 6 * HT; i++) begin
      step(1'(i % 2 == 0), 1'b0);
      clk_cnt++;
      if (prev_hs == 1 && bus.hsync == 1'b0) begin
        if (fall1 < 0) fall1 = clk_cnt;
        else if (fall2 < 0) fall2 = clk_cnt;
      end
      prev_hs = int'(bus.hsync);
    end
    chk("hsync_period_en_half", 32'(fall2 - fall1), 32'(2 * HT));

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 49) == 0) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) salt = int'($urandom_range(0, 255));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1499) == 0));
    end

`ifdef VGA_PAT_SCROLL_EN
    bus.mode = 2'd0;
    step(1'b1, 1'b1);
    for (int i = 0; i < 65 * FRAME; i++) begin
      step(1'b1, 1'b0);
      if (last_px == 0 && last_py == 0 && frames == 4)
        chk("scroll_f4", 32'(bus.pixel), 32'h01);
      if (last_px == 0 && last_py == 0 && frames == 64)
        chk("scroll_f64", 32'(bus.pixel), 32'h00);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
